// File: rtl/mdu_seq_pkg.sv
// Shared op codes, FSM states and decode helpers for the multiply/divide sequencer.
package mdu_seq_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// E-stage request / MDU status bundle between the pipeline and mdu_seq.
interface mdu_seq_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_val, rt_val, flush, input busy, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_core.sv
// Combinational MDU arithmetic: op/rs/rt plus current HI/LO accumulator -> 64-bit result.
module mdu_core
  import mdu_seq_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  logic signed [63:0]       prod_s;
  logic        [63:0]       prod_u;
  logic        [DATA_W-1:0] div_b, mag_a, mag_b, q_mag, r_mag;

  always_comb begin
    // Truncated 64-bit product of sign-extended operands equals the signed product.
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'd0, rs} * {32'd0, rt};
    div_b  = (rt == '0) ? 32'd1 : rt;
    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    mag_a  = rs[31] ? -rs : rs;
    mag_b  = rt[31] ? -rt : rt;
    if (mag_b == '0) mag_b = 32'd1;
    q_mag  = mag_a / mag_b;
    r_mag  = mag_a % mag_b;

    {res_hi, res_lo} = {acc_hi, acc_lo};
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: if (rt != '0) begin
        res_lo = (rs[31] ^ rt[31]) ? -q_mag : q_mag;
        res_hi = rs[31] ? -r_mag : r_mag;
      end
      OP_DIVU: if (rt != '0) begin
        res_lo = rs / div_b;
        res_hi = rs % div_b;
      end
      OP_MADD:  {res_hi, res_lo} = {acc_hi, acc_lo} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {acc_hi, acc_lo} + prod_u;
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; busy for the op latency, commit at the end.
// Define MDU_MADD_EN to accept MADD/MADDU; otherwise they decode as no-ops.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input logic     clk,
  input logic     reset,
  mdu_seq_if.slave bus
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] pend_hi, pend_lo, hi_q, lo_q, res_hi, res_lo;
  logic              accept, long_op, pend_ld, commit, hi_we, lo_we;

  mdu_core u_core (
    .op     (bus.op),
    .rs     (bus.rs_val),
    .rt     (bus.rt_val),
    .acc_hi (hi_q),
    .acc_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign accept = bus.start & ~bus.flush & (state == S_IDLE);

  always_comb begin
    case (bus.op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  long_op = 1'b1;
`endif
      default:                            long_op = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_ld   = 1'b0;
    commit    = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        if (long_op) begin
          state_nxt = S_BUSY;
          cnt_nxt   = is_div_op(bus.op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_ld   = 1'b1;
        end else begin
          hi_we = (bus.op == OP_MTHI);
          lo_we = (bus.op == OP_MTLO);
        end
      end
      S_BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pend_ld) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end
      if (commit)     hi_q <= pend_hi;
      else if (hi_we) hi_q <= bus.rs_val;
      if (commit)     lo_q <= pend_lo;
      else if (lo_we) lo_q <= bus.rs_val;
    end
  end

  assign bus.busy = (state == S_BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized + directed bench for mdu_seq against an arithmetic reference model of HI/LO.
module tb_mdu_seq;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_seq_if bus ();

  mdu_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: applies one accepted op to the model HI/LO and returns its busy length.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 0;
    case (op)
      4'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; lat = MULT_N; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; lat = MULT_N; end
      4'd3: begin
        lat = DIV_N;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      4'd4: begin
        lat = DIV_N;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
`ifdef MDU_MADD_EN
      4'd7: begin p = 64'(sa * sb); {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MULT_N; end
      4'd8: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MULT_N; end
`endif
      default: ;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    int exp_n, n;
    exp_n = 0;
    if (!fl) model_op(op, a, b, exp_n);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.flush = fl;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 64'(n), 64'(exp_n));
    check({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    int n;
    logic [3:0]  op;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("mult_hi_k", 64'(bus.hi), 64'hFFFFFFFF);
    check("mult_lo_k", 64'(bus.lo), 64'hFFFFFFFE);
    do_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    check("multu_hi_k", 64'(bus.hi), 64'h1);
    do_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_k", 64'(bus.lo), 64'hFFFFFFFD);
    check("div_hi_k", 64'(bus.hi), 64'hFFFFFFFF);
    do_op("divu0", 4'd4, 32'd7, 32'd0, 1'b0);
    do_op("divovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("divovf_lo_k", 64'(bus.lo), 64'h80000000);
    do_op("mthi", 4'd5, 32'h12345678, 32'd0, 1'b0);
    check("mthi_k", 64'(bus.hi), 64'h12345678);
    do_op("mtlo", 4'd6, 32'hA5A5A5A5, 32'd0, 1'b0);
    check("mtlo_k", 64'(bus.lo), 64'hA5A5A5A5);
    do_op("unk", 4'd12, 32'h1, 32'h1, 1'b0);
    do_op("flush_st", 4'd1, 32'd3, 32'd4, 1'b1);

    // Flush raised during the second busy cycle must not disturb the in-flight op.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd1; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      bus.flush = (n == 2);
      @(negedge clk);
    end
    bus.flush = 1'b0;
    m_hi = 32'd0; m_lo = 32'd12;
    check("flush_bsy_n", 64'(n), 64'(MULT_N));
    check("flush_bsy_hi", 64'(bus.hi), 64'd0);
    check("flush_bsy_lo", 64'(bus.lo), 64'd12);

    // Async reset in busy cycle 4 of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_hi", 64'(bus.hi), 64'd0);
    check("rstmid_lo", 64'(bus.lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    do_op("post_rst", 4'd1, 32'd2, 32'd3, 1'b0);
    check("post_rst_k", 64'(bus.lo), 64'd6);

    do_op("madd_hi", 4'd5, 32'd0, 32'd0, 1'b0);
    do_op("madd_lo", 4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    do_op("maddu", 4'd8, 32'd1, 32'd1, 1'b0);
    do_op("madd", 4'd7, 32'hFFFFFFFD, 32'd7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 10));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      do_op("rnd", op, a, b, ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
